// File: rtl/mult_share_ctrl_if.sv
// mult_share_ctrl_if
//   Request/response bundle between requesters, a response consumer and
//   mult_share_ctrl.
//   req_valid/req_ready : per-requester handshake (NREQ bits, one-hot ready)
//   req_a/req_b         : operands of requester i at [i*N +: N]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_p        : requester index and 2*N-bit product
//   master modport: requester/consumer side. slave modport: controller side.
interface mult_share_ctrl_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Round-robin controller sharing one 2-stage registered multiplier core
//   among NREQ requesters. One operation in flight at a time:
//   IDLE (grant + load) -> ISSUE -> CAPT (capture p_out) -> RESP (hold).
//   Ports:
//     clk, rst_n        : clock (rising edge), async active-low reset
//     bus (slave)       : request/response handshake bundle
//     o_ea, o_eb        : multiplier operand register load enables
//     o_data_a/o_data_b : operands to multiplier (zero unless loading)
//     i_p_out           : registered product from multiplier
//     o_busy            : high whenever not IDLE
//     o_op_count        : completed responses, wraps modulo 2^CNTW
module mult_share_ctrl #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_share_ctrl_if.slave    bus,
  output logic                o_ea,
  output logic                o_eb,
  output logic [N-1:0]        o_data_a,
  output logic [N-1:0]        o_data_b,
  input  logic [2*N-1:0]      i_p_out,
  output logic                o_busy,
  output logic [CNTW-1:0]     o_op_count
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_cur_id;
  logic [IDW-1:0]  r_rsp_id;
  logic [2*N-1:0]  r_rsp_p;
  logic [CNTW-1:0] r_op_count;
  logic [IDW-1:0]  w_grant;
  logic            w_found;
  logic            w_accept;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return IDW'(s % NREQ);
  endfunction

  // Round-robin search starting at r_rr_ptr; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req_valid[wrap_idx(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_grant = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // rst_n gates the grant so nothing is offered while reset is held.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    o_ea          = 1'b0;
    o_eb          = 1'b0;
    o_data_a      = '0;
    o_data_b      = '0;
    o_busy        = 1'b1;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (w_found && rst_n) begin
          w_accept               = 1'b1;
          bus.req_ready[w_grant] = 1'b1;
          o_ea                   = 1'b1;
          o_eb                   = 1'b1;
          o_data_a               = bus.req_a[int'(w_grant)*N +: N];
          o_data_b               = bus.req_b[int'(w_grant)*N +: N];
          w_state_nxt            = ISSUE;
        end
      end
      ISSUE: w_state_nxt = CAPT;
      CAPT:  w_state_nxt = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_cur_id   <= '0;
      r_rsp_id   <= '0;
      r_rsp_p    <= '0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_cur_id <= w_grant;
        r_rr_ptr <= wrap_idx(w_grant, 1);
      end
      if (r_state == CAPT) begin
        r_rsp_p  <= i_p_out;
        r_rsp_id <= r_cur_id;
      end
      if (r_state == RESP && bus.rsp_ready) r_op_count <= r_op_count + CNTW'(1);
    end
  end

  assign bus.rsp_id = r_rsp_id;
  assign bus.rsp_p  = r_rsp_p;
  assign o_op_count = r_op_count;
endmodule

// File: tb/tb_mult_share_ctrl.sv
module tb_mult_share_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ea, eb, busy;
  logic [7:0]  data_a, data_b;
  logic [15:0] p_out;
  logic [3:0]  op_count;

  logic [7:0]  ma, mb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] p;
  } exp_t;
  exp_t q[$];

  mult_share_ctrl_if #(.N(8), .NREQ(4)) bus ();

  mult_share_ctrl #(.N(8), .NREQ(4), .CNTW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_ea       (ea),
    .o_eb       (eb),
    .o_data_a   (data_a),
    .o_data_b   (data_b),
    .i_p_out    (p_out),
    .o_busy     (busy),
    .o_op_count (op_count)
  );

  always #5 clk = ~clk;

  // Multiplier core: enabled operand registers, then product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma    <= '0;
      mb    <= '0;
      p_out <= '0;
    end else begin
      if (ea) ma <= data_a;
      if (eb) mb <= data_b;
      p_out <= 16'(ma) * 16'(mb);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d p 0x%0h, none expected", bus.rsp_id, bus.rsp_p);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_p", 32'(bus.rsp_p), 32'(e.p));
      end
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
  endtask

  task automatic push(input logic [1:0] id, input logic [15:0] p);
    exp_t e;
    e.id = id;
    e.p  = p;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fair_p [5];
    logic [1:0]  fair_id [5];
    fair_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    fair_p  = '{16'h0003, 16'h0006, 16'h0009, 16'h000C, 16'h0003};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset state with a request already pending.
    bus.req_valid = 4'b0100;
    set_op(2, 8'hFF, 8'hFF);
    to_neg();
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    check("rst_ea", 32'(ea), 32'h0);
    check("rst_rsp_p", 32'(bus.rsp_p), 32'h0);
    to_pos();
    rst_n = 1'b1;

    // Single op on requester 2.
    to_neg();
    check("single_req_ready", 32'(bus.req_ready), 32'h4);
    check("single_ea", 32'(ea), 32'h1);
    check("single_eb", 32'(eb), 32'h1);
    check("single_data_a", 32'(data_a), 32'hFF);
    check("single_data_b", 32'(data_b), 32'hFF);
    push(2'd2, 16'hFE01);
    to_pos();
    bus.req_valid = '0;
    to_neg();
    check("issue_req_ready", 32'(bus.req_ready), 32'h0);
    check("issue_ea", 32'(ea), 32'h0);
    check("issue_data_a", 32'(data_a), 32'h0);
    check("issue_busy", 32'(busy), 32'h1);
    check("issue_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    to_pos();
    to_neg();
    check("capt_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    to_pos();
    to_neg();
    check("resp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    to_pos();
    to_neg();
    check("single_op_count", 32'(op_count), 32'h1);
    check("single_busy", 32'(busy), 32'h0);

    // Reset in IDLE to restart the pointer, then fairness with all valid.
    to_pos();
    rst_n = 1'b0;
    to_pos();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd3);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      to_neg();
      check("fair_grant", 32'(bus.req_ready), 32'(4'b0001 << fair_id[k]));
      push(fair_id[k], fair_p[k]);
      to_pos();
      if (k == 4) bus.req_valid = '0;
      repeat (3) begin
        to_neg();
        to_pos();
      end
    end
    to_neg();
    check("fair_op_count", 32'(op_count), 32'd5);

    // Backpressure: requester 2 in RESP, requester 1 waiting.
    to_pos();
    set_op(2, 8'd5, 8'd7);
    bus.req_valid = 4'b0100;
    to_neg();
    check("bp_grant2", 32'(bus.req_ready), 32'h4);
    push(2'd2, 16'h0023);
    to_pos();
    set_op(1, 8'd9, 8'd9);
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 1'b0;
    to_pos();
    to_pos();
    for (int c = 0; c < 6; c++) begin
      to_neg();
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_rsp_p", 32'(bus.rsp_p), 32'h0023);
      check("bp_rsp_id", 32'(bus.rsp_id), 32'h2);
      check("bp_req_ready", 32'(bus.req_ready), 32'h0);
      to_pos();
    end
    bus.rsp_ready = 1'b1;
    to_neg();
    to_pos();
    to_neg();
    check("bp_grant1_after_exit", 32'(bus.req_ready), 32'h2);
    push(2'd1, 16'h0051);
    to_pos();
    bus.req_valid = '0;
    repeat (3) to_pos();
    to_neg();
    check("bp_op_count", 32'(op_count), 32'd7);

    // Operand change after acceptance.
    to_pos();
    set_op(0, 8'h12, 8'h10);
    bus.req_valid = 4'b0001;
    to_neg();
    check("chg_grant0", 32'(bus.req_ready), 32'h1);
    push(2'd0, 16'h0120);
    to_pos();
    bus.req_valid = '0;
    set_op(0, 8'h34, 8'h10);
    repeat (3) to_pos();
    to_neg();
    check("chg_op_count", 32'(op_count), 32'd8);

    // Reset during CAPT discards the in-flight result.
    to_pos();
    set_op(3, 8'd2, 8'd3);
    bus.req_valid = 4'b1000;
    to_neg();
    check("mid_grant3", 32'(bus.req_ready), 32'h8);
    to_pos();
    bus.req_valid = '0;
    to_pos();
    rst_n = 1'b0;
    to_neg();
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_op_count", 32'(op_count), 32'h0);
    to_pos();
    rst_n = 1'b1;
    set_op(1, 8'd4, 8'd5);
    set_op(3, 8'd6, 8'd7);
    bus.req_valid = 4'b1010;
    to_neg();
    check("mid_grant1_first", 32'(bus.req_ready), 32'h2);
    push(2'd1, 16'h0014);
    to_pos();
    bus.req_valid = 4'b1000;
    repeat (3) to_pos();
    to_neg();
    check("mid_grant3_next", 32'(bus.req_ready), 32'h8);
    push(2'd3, 16'h002A);
    to_pos();
    bus.req_valid = '0;
    repeat (3) to_pos();

    // Counter wrap: 15 more ops brings the total since reset to 17.
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 15; k++) begin
      set_op(0, 8'(k + 1), 8'd2);
      to_neg();
      check("wrap_count_step", 32'(op_count), 32'((2 + k) % 16));
      check("wrap_grant0", 32'(bus.req_ready), 32'h1);
      push(2'd0, 16'(2 * (k + 1)));
      to_pos();
      if (k == 14) bus.req_valid = '0;
      repeat (3) to_pos();
    end
    to_neg();
    check("wrap_op_count", 32'(op_count), 32'd1);

    for (int c = 0; c < 20 && q.size() != 0; c++) to_neg();
    check("scoreboard_empty", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
